// File: rtl/ts_sched_pkg.sv
// Shared types and constants for the transmit scheduler: FSM encoding, queue ids, watchdog width.
package ts_sched_pkg;

  typedef enum logic [2:0] {
    TS_IDLE      = 3'd0,
    TS_RD        = 3'd1,
    TS_LATCH     = 3'd2,
    TS_ISSUE     = 3'd3,
    TS_WAIT_DONE = 3'd4
  } ts_state_e;

  localparam logic [1:0] QID_0 = 2'd0;
  localparam logic [1:0] QID_1 = 2'd1;
  localparam logic [1:0] QID_2 = 2'd2;
  localparam logic [1:0] QID_3 = 2'd3;

  localparam int WD_W = 12;

  function automatic logic [3:0] qid_onehot(input logic [1:0] qid);
    return 4'b0001 << qid;
  endfunction

endpackage

// File: rtl/ts_prio_enc.sv
// Strict-priority grant encoder (Q0 highest); also reports whether the selected queue is empty.
module ts_prio_enc
  import ts_sched_pkg::*;
(
  input  logic [3:0] grant_i,
  input  logic [3:0] empty_i,
  output logic [1:0] sel_o,
  output logic       any_o,
  output logic       sel_empty_o
);

  always_comb begin
    sel_o = QID_0;
    if (grant_i[0])      sel_o = QID_0;
    else if (grant_i[1]) sel_o = QID_1;
    else if (grant_i[2]) sel_o = QID_2;
    else if (grant_i[3]) sel_o = QID_3;
  end

  assign any_o       = |grant_i;
  assign sel_empty_o = empty_i[sel_o];

endmodule

// File: rtl/ts_sched.sv
// Transmit scheduler: pops one descriptor per gate-control grant and hands it to EBM.
// Optional WAIT_DONE watchdog with out_ts_timeout when TS_WATCHDOG_EN is defined.
module ts_sched
  import ts_sched_pkg::*;
#(
  parameter int DESC_W = 20,
  parameter int CNT_W  = 16
`ifdef TS_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC = 4095
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_ts_schedule_valid,
  input  logic [3:0]            in_ts_fifo_empty,
  output logic [3:0]            out_ts_q_rden,
  output logic                  out_ts_q2_rden,
  input  logic [4*DESC_W-1:0]   in_ts_q_rdata,
  input  logic                  in_ts_bw_discard,
  output logic                  out_ts_desc_valid,
  output logic [DESC_W+2:0]     out_ts_desc,
  input  logic                  in_ts_desc_ready,
  input  logic                  in_ts_pkt_done,
  output logic                  out_ts_busy,
  output logic                  out_ts_underrun,
  output logic                  out_ts_sched_err,
  output logic [4*CNT_W-1:0]    out_ts_q_cnt
`ifdef TS_WATCHDOG_EN
  ,
  output logic                  out_ts_timeout
`endif
);

  // IDLE: wait grant | RD: pop pulse | LATCH: capture rdata | ISSUE: offer to EBM | WAIT_DONE: wait pkt_done
  ts_state_e state_q, state_d;

  logic [1:0]              sel_q, sel_d;
  logic [3:0]              rden_q, rden_d;
  logic [DESC_W+2:0]       desc_q, desc_d;
  logic                    desc_valid_q, desc_valid_d;
  logic                    underrun_q, underrun_d;
  logic                    sched_err_q, sched_err_d;
  logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0][DESC_W-1:0]  rdata_w;

  logic [1:0] pe_sel;
  logic       pe_any;
  logic       pe_sel_empty;

`ifdef TS_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  assign rdata_w = in_ts_q_rdata;

  ts_prio_enc u_prio_enc (
    .grant_i     (in_ts_schedule_valid),
    .empty_i     (in_ts_fifo_empty),
    .sel_o       (pe_sel),
    .any_o       (pe_any),
    .sel_empty_o (pe_sel_empty)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    rden_d       = '0;
    desc_d       = desc_q;
    desc_valid_d = desc_valid_q;
    underrun_d   = 1'b0;
    sched_err_d  = sched_err_q | ((state_q != TS_IDLE) && pe_any);
    cnt_d        = cnt_q;
`ifdef TS_WATCHDOG_EN
    wd_d         = wd_q;
    timeout_d    = 1'b0;
`endif

    case (state_q)
      TS_IDLE: begin
        if (pe_any) begin
          if (pe_sel_empty) begin
            underrun_d = 1'b1;
          end else begin
            rden_d  = qid_onehot(pe_sel);
            sel_d   = pe_sel;
            state_d = TS_RD;
          end
        end
      end
      TS_RD: begin
        state_d = TS_LATCH;
      end
      TS_LATCH: begin
        // Only Q2 is bandwidth-policed by GC, so its verdict is meaningless for other queues.
        desc_d       = {(sel_q == QID_2) && in_ts_bw_discard, sel_q, rdata_w[sel_q]};
        desc_valid_d = 1'b1;
        state_d      = TS_ISSUE;
      end
      TS_ISSUE: begin
        if (in_ts_desc_ready) begin
          desc_valid_d = 1'b0;
          cnt_d[sel_q] = cnt_q[sel_q] + 1'b1;
          state_d      = TS_WAIT_DONE;
`ifdef TS_WATCHDOG_EN
          wd_d         = WD_LOAD;
`endif
        end
      end
      TS_WAIT_DONE: begin
        if (in_ts_pkt_done) begin
          state_d = TS_IDLE;
        end
`ifdef TS_WATCHDOG_EN
        else if (wd_q == '0) begin
          timeout_d = 1'b1;
          state_d   = TS_IDLE;
        end else begin
          wd_d = wd_q - 1'b1;
        end
`endif
      end
      default: begin
        state_d = TS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TS_IDLE;
      sel_q        <= QID_0;
      rden_q       <= '0;
      desc_q       <= '0;
      desc_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      sched_err_q  <= 1'b0;
      cnt_q        <= '0;
`ifdef TS_WATCHDOG_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      rden_q       <= rden_d;
      desc_q       <= desc_d;
      desc_valid_q <= desc_valid_d;
      underrun_q   <= underrun_d;
      sched_err_q  <= sched_err_d;
      cnt_q        <= cnt_d;
`ifdef TS_WATCHDOG_EN
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign out_ts_q_rden     = rden_q;
  assign out_ts_q2_rden    = rden_q[2];
  assign out_ts_desc_valid = desc_valid_q;
  assign out_ts_desc       = desc_q;
  assign out_ts_busy       = (state_q != TS_IDLE);
  assign out_ts_underrun   = underrun_q;
  assign out_ts_sched_err  = sched_err_q;
  assign out_ts_q_cnt      = cnt_q;
`ifdef TS_WATCHDOG_EN
  assign out_ts_timeout    = timeout_q;
`endif

endmodule
